// File: rtl/down_counter_sequencer_if.sv
// Signal bundle between the down-counter sequencer and its surroundings:
// run control, pacing tick, counter hookup and status pulses.
interface down_counter_sequencer_if;
   logic       start;
   logic [3:0] period;
   logic [3:0] reps;
   logic       tick;
   logic       abort;
   logic       coD;
   logic       clkEN;
   logic       ldcntD;
   logic       cntD;
   logic [3:0] NumData;
   logic       busy;
   logic       period_pulse;
   logic       done;
   logic [3:0] rep_left;

   modport master (
      input  start, period, reps, tick, abort, coD,
      output clkEN, ldcntD, cntD, NumData, busy, period_pulse, done, rep_left
   );

   modport slave (
      output start, period, reps, tick, abort, coD,
      input  clkEN, ldcntD, cntD, NumData, busy, period_pulse, done, rep_left
   );
endinterface

// File: rtl/down_counter_sequencer.sv
// Runs a programmed number of fixed-length periods on the 4-bit loadable
// down counter, reloading at each terminal count and pacing with tick.
module down_counter_sequencer (
   input  logic                        clock,
   input  logic                        reset,
   down_counter_sequencer_if.master    bus
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COUNT, S_DONE} state_t;

   state_t     r_state, w_next;
   logic [3:0] r_period_q;
   logic [3:0] r_rep_left;
   logic       r_period_pulse;
   logic       r_done;
   logic       w_accept;
   logic       w_term;
   logic       w_last;
   logic       w_active;

   assign w_accept = bus.start && (bus.reps != 4'd0);
   assign w_active = (r_state == S_LOAD) || (r_state == S_COUNT);
   assign w_last   = (r_rep_left == 4'd1);
   // terminal tick of a period; abort wins over tick and coD
   assign w_term   = (r_state == S_COUNT) && bus.tick && bus.coD && !bus.abort;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_next = S_LOAD;
         S_LOAD: begin
            if (bus.abort)     w_next = S_IDLE;
            else if (bus.tick) w_next = S_COUNT;
         end
         S_COUNT: begin
            if (bus.abort)           w_next = S_IDLE;
            else if (w_term && w_last) w_next = S_DONE;
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      bus.clkEN  = 1'b0;
      bus.ldcntD = 1'b0;
      bus.cntD   = 1'b0;
      case (r_state)
         S_LOAD: begin
            bus.clkEN  = bus.tick;
            bus.ldcntD = 1'b1;
         end
         S_COUNT: begin
            bus.clkEN  = bus.tick;
            // reload on the terminal tick itself so periods are back to back
            bus.ldcntD = bus.coD && !w_last;
            bus.cntD   = !bus.coD;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_period_q     <= 4'd0;
         r_rep_left     <= 4'd0;
         r_period_pulse <= 1'b0;
         r_done         <= 1'b0;
      end else begin
         r_period_pulse <= w_term;
         r_done         <= w_term && w_last;
         if ((r_state == S_IDLE) && w_accept) begin
            r_period_q <= bus.period;
            r_rep_left <= bus.reps;
         end else if (w_active && bus.abort) begin
            r_rep_left <= 4'd0;
         end else if (w_term) begin
            r_rep_left <= r_rep_left - 4'd1;
         end
      end
   end

   assign bus.NumData      = r_period_q;
   assign bus.busy         = w_active;
   assign bus.period_pulse = r_period_pulse;
   assign bus.done         = r_done;
   assign bus.rep_left     = r_rep_left;

endmodule

// File: tb/tb_down_counter_sequencer.sv
// Bench for down_counter_sequencer driving a behavioural 4-bit loadable
// down counter; table-driven vectors plus hand-written corner sequences.
module tb_down_counter_sequencer;

   logic clock;
   logic reset;
   logic [3:0] r_cnt;
   int n_tests = 0;
   int n_fail  = 0;

   down_counter_sequencer_if bus ();

   down_counter_sequencer dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.master)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // the external counter: preset 1111, load over decrement, coD at 1
   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_cnt <= 4'hF;
      else if (bus.clkEN) begin
         if (bus.ldcntD)    r_cnt <= bus.NumData;
         else if (bus.cntD) r_cnt <= r_cnt - 4'd1;
      end
   end
   assign bus.coD = (r_cnt == 4'd1);

   typedef struct {
      logic       start;
      logic [3:0] period;
      logic [3:0] reps;
      logic       tick;
      logic       abort;
      logic       e_clken;
      logic       e_ld;
      logic       e_dec;
      logic       e_busy;
      logic       e_pp;
      logic       e_done;
      logic [3:0] e_rep;
      logic [3:0] e_cv;
      logic [3:0] e_nd;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic st, input logic [3:0] per, input logic [3:0] rp,
                      input logic tk, input logic ab,
                      input logic ce, input logic ld, input logic dc,
                      input logic bz, input logic pp, input logic dn,
                      input logic [3:0] rl, input logic [3:0] cv, input logic [3:0] nd);
      vec_t v;
      v.start = st; v.period = per; v.reps = rp; v.tick = tk; v.abort = ab;
      v.e_clken = ce; v.e_ld = ld; v.e_dec = dc;
      v.e_busy = bz; v.e_pp = pp; v.e_done = dn;
      v.e_rep = rl; v.e_cv = cv; v.e_nd = nd;
      vq.push_back(v);
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk_reg(input string nm, input logic bz, input logic pp,
                          input logic dn, input logic [3:0] rl);
      chk({nm, ".busy"}, bus.busy, bz);
      chk({nm, ".period_pulse"}, bus.period_pulse, pp);
      chk({nm, ".done"}, bus.done, dn);
      chk({nm, ".rep_left"}, bus.rep_left, rl);
   endtask

   task automatic set_in(input logic st, input logic [3:0] per, input logic [3:0] rp,
                         input logic tk, input logic ab);
      bus.start = st; bus.period = per; bus.reps = rp; bus.tick = tk; bus.abort = ab;
   endtask

   initial begin
      set_in(0, 0, 0, 1, 0);
      reset = 1'b1;

      // zero reps is ignored (counter still at reset value 15)
      add(1,3,0,1,0, 0,0,0, 0,0,0,0,15,0);
      // basic run: period 3, reps 2; start while busy and in DONE ignored
      add(1,3,2,1,0, 0,0,0, 1,0,0,2,15,3);
      add(0,3,2,1,0, 1,1,0, 1,0,0,2, 3,3);
      add(1,5,7,1,0, 1,0,1, 1,0,0,2, 2,3);
      add(1,5,7,1,0, 1,0,1, 1,0,0,2, 1,3);
      add(0,3,2,1,0, 1,1,0, 1,1,0,1, 3,3);
      add(0,3,2,1,0, 1,0,1, 1,0,0,1, 2,3);
      add(0,3,2,1,0, 1,0,1, 1,0,0,1, 1,3);
      add(0,3,2,1,0, 1,0,0, 0,1,1,0, 1,3);
      add(1,6,2,1,0, 0,0,0, 0,0,0,0, 1,3);
      // period 1, reps 3: a pulse on every tick
      add(1,1,3,1,0, 0,0,0, 1,0,0,3, 1,1);
      add(0,1,3,1,0, 1,1,0, 1,0,0,3, 1,1);
      add(0,1,3,1,0, 1,1,0, 1,1,0,2, 1,1);
      add(0,1,3,1,0, 1,1,0, 1,1,0,1, 1,1);
      add(0,1,3,1,0, 1,0,0, 0,1,1,0, 1,1);
      add(0,1,3,1,0, 0,0,0, 0,0,0,0, 1,1);
      // tick pacing: period 2, reps 1, tick every 3rd cycle
      add(1,2,1,1,0, 0,0,0, 1,0,0,1, 1,2);
      add(0,2,1,0,0, 0,1,0, 1,0,0,1, 1,2);
      add(0,2,1,0,0, 0,1,0, 1,0,0,1, 1,2);
      add(0,2,1,1,0, 1,1,0, 1,0,0,1, 2,2);
      add(0,2,1,0,0, 0,0,1, 1,0,0,1, 2,2);
      add(0,2,1,0,0, 0,0,1, 1,0,0,1, 2,2);
      add(0,2,1,1,0, 1,0,1, 1,0,0,1, 1,2);
      add(0,2,1,0,0, 0,0,0, 1,0,0,1, 1,2);
      add(0,2,1,0,0, 0,0,0, 1,0,0,1, 1,2);
      add(0,2,1,1,0, 1,0,0, 0,1,1,0, 1,2);
      add(0,2,1,1,0, 0,0,0, 0,0,0,0, 1,2);

      step();
      chk_reg("reset", 0, 0, 0, 0);
      chk("reset.NumData", bus.NumData, 0);
      chk("reset.cnt", r_cnt, 15);
      reset = 1'b0;

      foreach (vq[i]) begin
         set_in(vq[i].start, vq[i].period, vq[i].reps, vq[i].tick, vq[i].abort);
         #1;
         chk($sformatf("v%0d.clkEN", i), bus.clkEN, vq[i].e_clken);
         chk($sformatf("v%0d.ldcntD", i), bus.ldcntD, vq[i].e_ld);
         chk($sformatf("v%0d.cntD", i), bus.cntD, vq[i].e_dec);
         step();
         chk_reg($sformatf("v%0d", i), vq[i].e_busy, vq[i].e_pp, vq[i].e_done, vq[i].e_rep);
         chk($sformatf("v%0d.cnt", i), r_cnt, vq[i].e_cv);
         chk($sformatf("v%0d.NumData", i), bus.NumData, vq[i].e_nd);
      end

      // period 0 means 16 ticks: counter 0,15..1 then done
      set_in(1, 0, 1, 1, 0);
      step();
      set_in(0, 0, 0, 1, 0);
      step();
      chk("p0.load_cnt", r_cnt, 0);
      chk("p0.NumData", bus.NumData, 0);
      for (int k = 1; k <= 15; k++) begin
         step();
         chk($sformatf("p0.cnt%0d", k), r_cnt, 16 - k);
         chk($sformatf("p0.nodone%0d", k), bus.done, 0);
      end
      step();
      chk_reg("p0.end", 0, 1, 1, 0);
      step();
      chk_reg("p0.idle", 0, 0, 0, 0);

      // abort in COUNT at counter value 2
      set_in(1, 4, 2, 1, 0);
      step();
      set_in(0, 0, 0, 1, 0);
      step(); step(); step();
      chk("ab.cnt", r_cnt, 2);
      bus.abort = 1'b1;
      step();
      bus.abort = 1'b0;
      #1;
      chk_reg("ab.next", 0, 0, 0, 0);
      chk("ab.clkEN", bus.clkEN, 0);
      chk("ab.ldcntD", bus.ldcntD, 0);
      chk("ab.cntD", bus.cntD, 0);
      step();
      chk_reg("ab.after", 0, 0, 0, 0);
      // a fresh run after abort behaves normally
      set_in(1, 2, 1, 1, 0);
      step();
      set_in(0, 0, 0, 1, 0);
      step();
      chk("ab.rerun_load", r_cnt, 2);
      step();
      chk_reg("ab.rerun_mid", 1, 0, 0, 1);
      step();
      chk_reg("ab.rerun_end", 0, 1, 1, 0);
      step();

      // async reset between edges while a pulse is showing
      set_in(1, 1, 3, 1, 0);
      step();
      set_in(0, 0, 0, 1, 0);
      step(); step();
      chk_reg("rst.pre", 1, 1, 0, 2);
      #2;
      reset = 1'b1;
      #1;
      chk_reg("rst.async", 0, 0, 0, 0);
      chk("rst.cnt", r_cnt, 15);
      chk("rst.NumData", bus.NumData, 0);
      step();
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         chk_reg($sformatf("rst.idle%0d", k), 0, 0, 0, 0);
         chk($sformatf("rst.clkEN%0d", k), bus.clkEN, 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
